// File: rtl/gcd_engine_if.sv
// gcd_engine_if: operand/result valid-ready bundle for gcd_engine.
interface gcd_engine_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     gcd_out;
    logic                 zero_flag;
    logic [CNT_WIDTH-1:0] iter_count;
    logic                 busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, zero_flag, iter_count, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, zero_flag, iter_count, busy
    );
endinterface

// File: rtl/gcd_engine.sv
// gcd_engine: self-sequencing subtract-and-compare GCD with valid/ready in and out.
module gcd_engine #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    gcd_engine_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     r_gcd;
    logic                 r_zero;
    logic [CNT_WIDTH-1:0] r_iter;
    logic                 w_any_zero;

    assign w_any_zero     = (r_a == '0) || (r_b == '0);
    assign bus.in_ready   = r_state == S_IDLE;
    assign bus.out_valid  = r_state == S_DONE;
    assign bus.busy       = r_state == S_COMP;
    assign bus.gcd_out    = r_gcd;
    assign bus.zero_flag  = r_zero;
    assign bus.iter_count = r_iter;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_gcd   <= '0;
            r_zero  <= 1'b0;
            r_iter  <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.in_valid) begin
                r_a     <= bus.a_in;
                r_b     <= bus.b_in;
                r_cnt   <= '0;
                r_state <= S_COMP;
            end
        end else if (r_state == S_COMP) begin
            if (w_any_zero || r_a == r_b) begin
                r_gcd   <= w_any_zero ? (r_a | r_b) : r_a;
                r_zero  <= w_any_zero;
                r_iter  <= r_cnt;
                r_state <= S_DONE;
            end else begin
                // Always larger minus smaller, so neither operand can underflow.
                r_a   <= (r_a > r_b) ? r_a - r_b : r_a;
                r_b   <= (r_a > r_b) ? r_b : r_b - r_a;
                r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed and random checks of gcd_engine at 16/16 and 8/4.
module tb_gcd_engine;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    gcd_engine_if #(.WIDTH(16), .CNT_WIDTH(16)) bus ();
    gcd_engine_if #(.WIDTH(8),  .CNT_WIDTH(4))  bus8 ();

    gcd_engine #(.WIDTH(16), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.slave)
    );
    gcd_engine #(.WIDTH(8), .CNT_WIDTH(4)) dut8 (
        .clock(clock), .reset_n(reset_n), .bus(bus8.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_gcd(input int a, input int b, output int g, output int z, output int k);
        k = 0;
        z = (a == 0 || b == 0) ? 1 : 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a = a - b;
            else b = b - a;
            k++;
        end
        g = (a == 0 || b == 0) ? (a | b) : a;
    endfunction

    task automatic run(input int a, input int b, input int g, input int z, input int k, input string tag);
        int lat;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a_in = 16'(a);
        bus.b_in = 16'(b);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        lat = 0;
        while (!bus.out_valid && lat < 1000) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(k + 1));
        chk({tag, "_gcd"}, 32'(bus.gcd_out), 32'(g));
        chk({tag, "_zero"}, 32'(bus.zero_flag), 32'(z));
        chk({tag, "_iter"}, 32'(bus.iter_count), 32'(k));
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_ov_drop"}, 32'(bus.out_valid), 0);
        chk({tag, "_idle"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        int g, z, k, a, b, lat, stall;
        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_gcd", 32'(bus.gcd_out), 0);
        chk("rst_zero", 32'(bus.zero_flag), 0);
        chk("rst_iter", 32'(bus.iter_count), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run(48, 18, 6, 0, 4, "g48_18");
        handoff("g48_18");
        run(0, 35, 35, 1, 0, "g0_35");
        handoff("g0_35");
        run(0, 0, 0, 1, 0, "g0_0");
        handoff("g0_0");

        bus.out_ready = 1'b0;
        run(21, 14, 7, 0, 2, "bp");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a_in = 16'd100;
            bus.b_in = 16'd30;
            @(posedge clock); #1;
            chk("bp_ov_held", 32'(bus.out_valid), 1);
            chk("bp_gcd_held", 32'(bus.gcd_out), 7);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        handoff("bp");
        @(posedge clock); #1;
        chk("bp_single", 32'(bus.out_valid), 0);
        chk("bp_no_busy", 32'(bus.busy), 0);

        run(9, 9, 9, 0, 0, "g9_9");
        handoff("g9_9");

        bus.in_valid = 1'b1; bus.a_in = 16'd48; bus.b_in = 16'd18;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_gcd", 32'(bus.gcd_out), 0);
        @(posedge clock); #3;
        reset_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            lat += int'(bus.out_valid);
        end
        chk("abort_no_result", 32'(lat), 0);

        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, 300));
            b = int'($urandom_range(0, 300));
            ref_gcd(a, b, g, z, k);
            bus.out_ready = 1'b0;
            run(a, b, g, z, k, "rnd");
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                @(posedge clock); #1;
                chk("rnd_stall_gcd", 32'(bus.gcd_out), 32'(g));
            end
            handoff("rnd");
        end
        bus.out_ready = 1'b1;

        bus8.in_valid = 1'b1; bus8.a_in = 8'd1; bus8.b_in = 8'd255;
        @(posedge clock); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 1000) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("sat_lat", 32'(lat), 255);
        chk("sat_gcd", 32'(bus8.gcd_out), 1);
        chk("sat_iter", 32'(bus8.iter_count), 15);
        chk("sat_zero", 32'(bus8.zero_flag), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
